// File: rtl/jtag_tap_target_if.sv
// JTAG pin bundle plus the USER data-register side-band.
// The player side drives master and the TAP responder uses slave.
interface jtag_tap_target_if #(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 32
);
  logic                tck;
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_oe;
  logic [3:0]          tap_state;
  logic [IR_WIDTH-1:0] ir_value;
  logic [DR_WIDTH-1:0] user_dr_in;
  logic [DR_WIDTH-1:0] user_dr_out;
  logic                update_dr;

  modport master (
    output tck, tms, tdi, user_dr_in,
    input  tdo, tdo_oe, tap_state, ir_value, user_dr_out, update_dr
  );

  modport slave (
    input  tck, tms, tdi, user_dr_in,
    output tdo, tdo_oe, tap_state, ir_value, user_dr_out, update_dr
  );
endinterface

// File: rtl/jtag_tap_target.sv
// IEEE 1149.1 TAP responder, oversampled in the clk domain.
// Implements IR, IDCODE, BYPASS and one USER data register.
module jtag_tap_target #(
  parameter int                     IR_WIDTH     = 4,
  parameter int                     DR_WIDTH     = 32,
  parameter logic [31:0]            IDCODE_VALUE = 32'h1234_50DD,
  parameter logic [IR_WIDTH-1:0]    INSTR_IDCODE = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0]    INSTR_USER   = IR_WIDTH'(4'b1000)
) (
  input  logic               clk,
  input  logic               reset,
  jtag_tap_target_if.slave   bus
);

  localparam int SR_WIDTH = (DR_WIDTH > 32) ? DR_WIDTH : 32;

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI     = 4'hC,
    SEL_DR   = 4'h7, CAP_DR  = 4'h6, SH_DR   = 4'h2, EX1_DR  = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR  = 4'h0, UPD_DR  = 4'h5,
    SEL_IR   = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA, EX1_IR  = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR  = 4'h8, UPD_IR  = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} dr_sel_t;

  logic [2:0]          tck_sync;
  logic [1:0]          tms_sync;
  logic [1:0]          tdi_sync;
  logic                tck_rise, tck_fall, tms_s, tdi_s;

  tap_state_t          state, state_next;
  logic [IR_WIDTH-1:0] ir_sr, ir_reg;
  logic [SR_WIDTH-1:0] dr_sr, dr_capture, dr_shifted;
  logic [DR_WIDTH-1:0] user_reg;
  logic                upd_pulse, tdo_bit, tdo_en;
  dr_sel_t             dr_sel;

  function automatic tap_state_t next_state(input tap_state_t s, input logic m);
    case (s)
      TLR:      return m ? TLR      : RTI;
      RTI:      return m ? SEL_DR   : RTI;
      SEL_DR:   return m ? SEL_IR   : CAP_DR;
      CAP_DR:   return m ? EX1_DR   : SH_DR;
      SH_DR:    return m ? EX1_DR   : SH_DR;
      EX1_DR:   return m ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return m ? EX2_DR   : PAUSE_DR;
      EX2_DR:   return m ? UPD_DR   : SH_DR;
      UPD_DR:   return m ? SEL_DR   : RTI;
      SEL_IR:   return m ? TLR      : CAP_IR;
      CAP_IR:   return m ? EX1_IR   : SH_IR;
      SH_IR:    return m ? EX1_IR   : SH_IR;
      EX1_IR:   return m ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return m ? EX2_IR   : PAUSE_IR;
      EX2_IR:   return m ? UPD_IR   : SH_IR;
      UPD_IR:   return m ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction

  // Third tck stage exists only for edge detection; tms/tdi use stage two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
    end else begin
      tck_sync <= {tck_sync[1:0], bus.tck};
      tms_sync <= {tms_sync[0], bus.tms};
      tdi_sync <= {tdi_sync[0], bus.tdi};
    end
  end

  assign tck_rise   = tck_sync[1] & ~tck_sync[2];
  assign tck_fall   = ~tck_sync[1] & tck_sync[2];
  assign tms_s      = tms_sync[1];
  assign tdi_s      = tdi_sync[1];
  assign state_next = next_state(state, tms_s);

  always_comb begin
    if (ir_reg == INSTR_IDCODE)    dr_sel = SEL_IDCODE;
    else if (ir_reg == INSTR_USER) dr_sel = SEL_USER;
    else                           dr_sel = SEL_BYPASS;
  end

  // The shared shift register enters tdi at the selected register's MSB.
  always_comb begin
    dr_capture = '0;
    dr_shifted = dr_sr >> 1;
    case (dr_sel)
      SEL_IDCODE: begin
        dr_capture     = SR_WIDTH'(IDCODE_VALUE);
        dr_shifted[31] = tdi_s;
      end
      SEL_USER: begin
        dr_capture             = SR_WIDTH'(bus.user_dr_in);
        dr_shifted[DR_WIDTH-1] = tdi_s;
      end
      default: dr_shifted[0] = tdi_s;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TLR;
      ir_reg    <= INSTR_IDCODE;
      ir_sr     <= '0;
      dr_sr     <= '0;
      user_reg  <= '0;
      upd_pulse <= 1'b0;
      tdo_bit   <= 1'b0;
      tdo_en    <= 1'b0;
    end else begin
      // NOTE: default-low here makes update_dr a single-clk pulse.
      upd_pulse <= 1'b0;
      if (tck_rise) begin
        case (state)
          CAP_IR: ir_sr  <= IR_WIDTH'(1);
          SH_IR:  ir_sr  <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
          UPD_IR: ir_reg <= ir_sr;
          CAP_DR: dr_sr  <= dr_capture;
          SH_DR:  dr_sr  <= dr_shifted;
          UPD_DR: begin
            if (dr_sel == SEL_USER) begin
              user_reg  <= dr_sr[DR_WIDTH-1:0];
              upd_pulse <= 1'b1;
            end
          end
          default: ;
        endcase
        state <= state_next;
        if (state_next == TLR) ir_reg <= INSTR_IDCODE;
      end else if (tck_fall) begin
        tdo_en <= (state == SH_IR) || (state == SH_DR);
        case (state)
          SH_IR:   tdo_bit <= ir_sr[0];
          SH_DR:   tdo_bit <= dr_sr[0];
          default: tdo_bit <= 1'b0;
        endcase
      end
    end
  end

  assign bus.tap_state   = state;
  assign bus.ir_value    = ir_reg;
  assign bus.user_dr_out = user_reg;
  assign bus.update_dr   = upd_pulse;
  assign bus.tdo         = tdo_bit;
  assign bus.tdo_oe      = tdo_en;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Self-checking bench: pin-level TAP model delayed by the 3-clk sync latency,
// compared every clk, plus literal checks of the canonical JTAG scenarios.
module tb_jtag_tap_target;
  localparam int          IRW    = 4;
  localparam int          DRW    = 32;
  localparam logic [31:0] IDCODE = 32'h1234_50DD;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  jtag_tap_target_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) bus ();

  jtag_tap_target #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model (pin-level, no sync delay) -------------
  logic [3:0]  nxt_tab [16][2];
  logic [3:0]  m_st, m_ir, m_irs;
  logic [31:0] m_drs, m_udo;
  logic        m_bp, m_tdo, m_oe;
  int          m_upd_seq = 0;

  task automatic tab(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt_tab[s][0] = n0;
    nxt_tab[s][1] = n1;
  endtask

  task automatic init_table();
    tab(4'hF, 4'hC, 4'hF); tab(4'hC, 4'hC, 4'h7);
    tab(4'h7, 4'h6, 4'h4); tab(4'h6, 4'h2, 4'h1);
    tab(4'h2, 4'h2, 4'h1); tab(4'h1, 4'h3, 4'h5);
    tab(4'h3, 4'h3, 4'h0); tab(4'h0, 4'h2, 4'h5);
    tab(4'h5, 4'hC, 4'h7); tab(4'h4, 4'hE, 4'hF);
    tab(4'hE, 4'hA, 4'h9); tab(4'hA, 4'hA, 4'h9);
    tab(4'h9, 4'hB, 4'hD); tab(4'hB, 4'hB, 4'h8);
    tab(4'h8, 4'hA, 4'hD); tab(4'hD, 4'hC, 4'h7);
  endtask

  task automatic model_reset();
    m_st = 4'hF; m_ir = 4'h1; m_irs = '0; m_drs = '0; m_bp = 1'b0;
    m_tdo = 1'b0; m_oe = 1'b0; m_udo = '0;
  endtask

  function automatic logic is_bypass(input logic [3:0] ir);
    return !(ir == 4'h1 || ir == 4'h8);
  endfunction

  task automatic model_rise(input logic t_ms, input logic t_di);
    case (m_st)
      4'hE: m_irs = 4'h1;
      4'hA: m_irs = {t_di, m_irs[3:1]};
      4'hD: m_ir  = m_irs;
      4'h6: begin
        if (m_ir == 4'h1)      m_drs = IDCODE;
        else if (m_ir == 4'h8) m_drs = bus.user_dr_in;
        else                   m_bp  = 1'b0;
      end
      4'h2: begin
        if (is_bypass(m_ir)) m_bp  = t_di;
        else                 m_drs = {t_di, m_drs[31:1]};
      end
      4'h5: begin
        if (m_ir == 4'h8) begin
          m_udo = m_drs;
          m_upd_seq++;
        end
      end
      default: ;
    endcase
    m_st = nxt_tab[m_st][t_ms];
    if (m_st == 4'hF) m_ir = 4'h1;
  endtask

  task automatic model_fall();
    m_oe  = (m_st == 4'hA) || (m_st == 4'h2);
    m_tdo = (m_st == 4'hA) ? m_irs[0] :
            (m_st == 4'h2) ? (is_bypass(m_ir) ? m_bp : m_drs[0]) : 1'b0;
  endtask

  // ---------------- 3-clk delay line of expected outputs -------------------
  typedef struct packed {
    logic [3:0]  st;
    logic        tdo;
    logic        oe;
    logic [3:0]  ir;
    logic [31:0] udo;
    logic        upd;
  } exp_t;

  localparam exp_t RST_EXP = '{st: 4'hF, tdo: 1'b0, oe: 1'b0, ir: 4'h1, udo: 32'h0, upd: 1'b0};

  exp_t d0, d1, d2;
  int   last_seq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      d0 <= RST_EXP; d1 <= RST_EXP; d2 <= RST_EXP;
      last_seq <= m_upd_seq;
    end else begin
      d2 <= d1;
      d1 <= d0;
      d0 <= '{st: m_st, tdo: m_tdo, oe: m_oe, ir: m_ir, udo: m_udo,
              upd: (m_upd_seq != last_seq)};
      last_seq <= m_upd_seq;
    end
  end

  // ---------------- single checker process ---------------------------------
  string       lit_name [64];
  logic [31:0] lit_act  [64];
  logic [31:0] lit_exp  [64];
  int          lit_wr = 0;
  int          lit_rd = 0;
  int          total = 0, bad = 0, upd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.update_dr === 1'b1) upd_cnt++;
    if (!reset) begin
      check("tap_state",   32'(bus.tap_state),   32'(d2.st));
      check("tdo",         32'(bus.tdo),         32'(d2.tdo));
      check("tdo_oe",      32'(bus.tdo_oe),      32'(d2.oe));
      check("ir_value",    32'(bus.ir_value),    32'(d2.ir));
      check("user_dr_out", bus.user_dr_out,      d2.udo);
      check("update_dr",   32'(bus.update_dr),   32'(d2.upd));
    end
    while (lit_rd < lit_wr) begin
      check(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  // Literal expectations are queued here and compared by the checker above.
  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_name[lit_wr] = name;
    lit_act[lit_wr]  = act;
    lit_exp[lit_wr]  = exp;
    lit_wr++;
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic pulse(input logic t_ms, input logic t_di, input int lo,
                       output logic t_do, output logic t_oe);
    bus.tms = t_ms;
    bus.tdi = t_di;
    @(negedge clk);
    bus.tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (2) @(negedge clk);
    bus.tck = 1'b0;
    model_fall();
    repeat (lo - 1) @(negedge clk);
    t_do = bus.tdo;
    t_oe = bus.tdo_oe;
  endtask

  task automatic walk(input logic [7:0] seq, input int n);
    logic t_do, t_oe;
    for (int i = 0; i < n; i++) pulse(seq[i], 1'b0, 5, t_do, t_oe);
  endtask

  // Starts in CapIR/CapDR; leaves the TAP in Exit1 after n shifts.
  task automatic shift(input logic [31:0] din, input int n,
                       output logic [31:0] dout, output logic oe_all, output logic oe_exit);
    logic t_do, t_oe;
    dout = '0;
    pulse(1'b0, 1'b0, 5, t_do, t_oe);
    dout[0] = t_do;
    oe_all  = t_oe;
    oe_exit = 1'b0;
    for (int i = 0; i < n; i++) begin
      pulse(i == n - 1, din[i], 5, t_do, t_oe);
      if (i < n - 1) begin
        dout[i+1] = t_do;
        oe_all    = oe_all & t_oe;
      end else begin
        oe_exit = t_oe;
      end
    end
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    logic [31:0] dout;
    logic        oe_all, oe_exit, t_do, t_oe;
    int          cnt0;

    bus.tck = 1'b0; bus.tms = 1'b0; bus.tdi = 1'b0;
    bus.user_dr_in = 32'h0F0F_F0F0;
    init_table();
    model_reset();

    repeat (4) @(negedge clk);
    expect_val("reset tap_state",   32'(bus.tap_state), 32'hF);
    expect_val("reset ir_value",    32'(bus.ir_value),  32'h1);
    expect_val("reset tdo_oe",      32'(bus.tdo_oe),    32'h0);
    expect_val("reset user_dr_out", bus.user_dr_out,    32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // IDCODE read: TLR -> RTI -> SelDR -> CapDR -> ShDR
    walk(8'b0000_0010, 3);
    shift(32'h0, 32, dout, oe_all, oe_exit);
    expect_val("idcode tdo word", dout, 32'h1234_50DD);
    expect_val("idcode oe in ShDR", 32'(oe_all), 32'h1);
    expect_val("idcode oe after exit", 32'(oe_exit), 32'h0);
    walk(8'b01, 2);

    // IR capture pattern and BYPASS
    walk(8'b011, 3);
    shift(32'hF, 4, dout, oe_all, oe_exit);
    expect_val("ir capture tdo", dout, 32'h1);
    walk(8'b01, 2);
    expect_val("ir_value after F", 32'(bus.ir_value), 32'hF);
    walk(8'b01, 2);
    shift(32'b1101, 4, dout, oe_all, oe_exit);
    expect_val("bypass tdo", dout, 32'b1010);
    walk(8'b01, 2);

    // USER register round trip
    walk(8'b011, 3);
    shift(32'h8, 4, dout, oe_all, oe_exit);
    walk(8'b01, 2);
    expect_val("ir_value USER", 32'(bus.ir_value), 32'h8);
    walk(8'b01, 2);
    shift(32'hA5A5_5A5A, 32, dout, oe_all, oe_exit);
    expect_val("user capture tdo", dout, 32'h0F0F_F0F0);
    cnt0 = upd_cnt;
    walk(8'b01, 2);
    repeat (4) @(negedge clk);
    expect_val("user_dr_out", bus.user_dr_out, 32'hA5A5_5A5A);
    expect_val("update_dr pulse count", 32'(upd_cnt - cnt0), 32'h1);

    // Asynchronous reset in the middle of a DR shift
    walk(8'b01, 2);
    pulse(1'b0, 1'b1, 5, t_do, t_oe);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 5, t_do, t_oe);
    @(negedge clk);
    #3 reset = 1'b1;
    model_reset();
    #1;
    expect_val("midshift reset tap_state",   32'(bus.tap_state), 32'hF);
    expect_val("midshift reset ir_value",    32'(bus.ir_value),  32'h1);
    expect_val("midshift reset tdo_oe",      32'(bus.tdo_oe),    32'h0);
    expect_val("midshift reset user_dr_out", bus.user_dr_out,    32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Five tms=1 rises from PauseIR reach TLR
    walk(8'b0, 1);
    walk(8'b011, 3);
    shift(32'h5, 4, dout, oe_all, oe_exit);
    walk(8'b01, 2);
    expect_val("ir_value 5", 32'(bus.ir_value), 32'h5);
    walk(8'b011, 3);
    walk(8'b010, 3);
    expect_val("in PauseIR", 32'(bus.tap_state), 32'hB);
    walk(8'b1_1111, 5);
    expect_val("tlr state", 32'(bus.tap_state), 32'hF);
    expect_val("tlr ir_value", 32'(bus.ir_value), 32'h1);

    // Static tck with toggling tms/tdi must not move the TAP
    walk(8'b0, 1);
    for (int i = 0; i < 12; i++) begin
      bus.tms = ~bus.tms;
      bus.tdi = 1'($urandom);
      @(negedge clk);
    end
    expect_val("static tck state", 32'(bus.tap_state), 32'hC);

    // Random tms/tdi at tck = clk/4 against the model
    bus.user_dr_in = $urandom;
    for (int i = 0; i < 900; i++)
      pulse(1'($urandom), 1'($urandom), 2, t_do, t_oe);

    repeat (6) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/jtag_tap_target.md
# jtag_tap_target

IEEE 1149.1 TAP responder that sits at the far end of the JTAG vector player's tck/tms/tdi/tdo pins. It oversamples the JTAG pins in the fabric clock domain, runs the 16-state TAP controller, and implements IR, IDCODE, BYPASS and one USER data register. It serves as an on-board loopback target for calibrating the player's tck/tms/tdi/tdo delays and for self-testing recorded vectors without external silicon.

## Interface
- IR_WIDTH, 4: instruction register length.
- DR_WIDTH, 32: USER data register length (≥2).
- IDCODE_VALUE, 32'h1234_50DD: value captured by IDCODE; bit 0 must be 1.
- INSTR_IDCODE, 4'b0001: IDCODE opcode; also the IR reset value.
- INSTR_USER, 4'b1000: USER opcode. All other opcodes, including all-ones, select BYPASS.

Ports:
- clk  in  1  fabric clock; must run ≥4× tck frequency.
- reset  in  1  asynchronous, active-high reset.
- tck  in  1  JTAG clock, asynchronous to clk.
- tms  in  1  JTAG mode select, asynchronous.
- tdi  in  1  JTAG data in, asynchronous.
- tdo  out  1  JTAG data out; 0 when tdo_oe=0.
- tdo_oe  out  1  high while in Shift-DR/Shift-IR.
- tap_state  out  4  current TAP state, encoding below.
- ir_value  out  IR_WIDTH  current (updated) instruction.
- user_dr_in  in  DR_WIDTH  value loaded at Capture-DR under USER.
- user_dr_out  out  DR_WIDTH  value written at Update-DR under USER.
- update_dr  out  1  one-clk pulse on Update-DR under USER.

## Operation
- tck, tms and tdi each pass through a 2-FF synchronizer. A third tck register provides edge detection: rise = s2 & ~s3, fall = ~s2 & s3. The tms/tdi values used are the synchronized samples from the same cycle.
- State encoding: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- On each detected rise, the state advances per standard 1149.1 transitions using tms.
- **Rise-edge actions**, keyed on the state before the transition:
  - CapIR: ir_sr ← {0…01}.
  - ShIR: ir_sr ← {tdi, ir_sr[IR_WIDTH-1:1]}.
  - UpdIR: ir_value ← ir_sr.
  - CapDR: dr_sr is loaded by the selected register: IDCODE_VALUE, user_dr_in, or 0 for BYPASS.
  - ShDR: dr_sr shifts right with tdi entering at the selected register's MSB (bit 31, DR_WIDTH-1, or 0 for BYPASS).
  - UpdDR under USER: user_dr_out ← dr_sr, and update_dr is asserted for exactly that clk.
- TLR (entered, or held on any rise while in TLR): ir_value ← INSTR_IDCODE. user_dr_out is unchanged.
- **Fall-edge actions**:
  - In ShIR: tdo ← ir_sr[0], tdo_oe ← 1.
  - In ShDR: tdo ← dr_sr[0], tdo_oe ← 1.
  - In any other state: tdo ← 0, tdo_oe ← 0.
- Five consecutive rises with tms=1 reach TLR from any state.
- The shift register is shared and sized max(32, DR_WIDTH). Only the low bits of the selected register are meaningful.

## Timing
- **Reset values** (async assert):
  - tap_state = F, ir_value = INSTR_IDCODE.
  - tdo = 0, tdo_oe = 0, user_dr_out = 0, update_dr = 0.
  - Shift registers = 0, synchronizers = 0.
- Reset deassertion mid-shift returns to TLR. No partial update of ir_value or user_dr_out occurs.
- **Pin-to-state latency:** 3 clk cycles from a tck pin rise to the tap_state change. The same latency applies from a tck pin fall to the tdo change.
- The player must sample tdo ≥4 clk after its own tck fall.
- Each tck high and low phase must be ≥2 clk. Shorter pulses are out of spec, may be missed, and no recovery is required.
- Rise and fall cannot both be detected in one cycle, by construction.
- A tck that is static with tms/tdi toggling produces no state change.
- update_dr: exactly one clk pulse, asserted 3 clk after the tck rise that leaves UpdDR.

## Test plan
- **Reset:** assert reset mid-ShDR → tap_state = F, ir_value = 0001, tdo_oe = 0, user_dr_out = 0 immediately (async).
- **TLR from anywhere:** from PauseIR, apply 5 tck with tms=1 → tap_state = F, ir_value = 0001.
- **IDCODE read:** reset, tms sequence 0,1,0,0 → ShDR; shift 32 bits → tdo gives 0x123450DD LSB first; tdo_oe = 1 only during ShDR.
- **IR capture/BYPASS:** go to ShIR, shift in 1111 → tdo shows 1,0,0,0. Then UpdIR → ir_value = F. In ShDR shift 1,0,1,1 → tdo gives 0,1,0,1 (one-bit delay, leading 0).
- **USER:** load IR 1000; set user_dr_in = 0x0F0F_F0F0. Shift 0xA5A5_5A5A in → tdo gives 0x0F0FF0F0 LSB first. On UpdDR: user_dr_out = 0xA5A55A5A and update_dr pulses once.
- **Clock ratio:** tck = clk/4 with random tms/tdi vs a reference TAP model → tap_state and tdo match every cycle. tck = clk/2 may fail (out of spec, not checked).
